seq_bit_serializer: RTL

//   Parallel-to-serial front end for the sequence-detector FSMs.

---
 rtl/seq_det_pkg.sv | 22 ++
 rtl/seq_bit_serializer_if.sv | 14 +
 rtl/seq_bit_serializer_hold.sv | 45 ++++
 rtl/seq_bit_serializer.sv | 101 ++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared types and constants for the sequence-detector front end
package seq_det_pkg;

    // Serializer control states.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } ser_state_t;

    localparam int   DEFAULT_WIDTH = 8;
    localparam int   CNT_W         = $clog2(DEFAULT_WIDTH);

    // Value driven on the serial line when no word is being shifted.
    // A 0 fill can never complete a 1011 pattern on its own.
    localparam logic SEQ_IDLE_BIT  = 1'b0;

    // Bit-counter width for a given word width (at least 1 bit).
    function automatic int cnt_width(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/seq_bit_serializer_if.sv
// rtl/seq_bit_serializer_if.sv - parallel word valid/ready handshake bundle
//   in_data  : WIDTH-bit word, driven by the producer
//   in_valid : in_data is valid, driven by the producer
//   in_ready : word can be accepted, driven by the serializer
interface seq_bit_serializer_if #(
    parameter int WIDTH = 8
) ();
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/seq_bit_serializer_hold.sv
// rtl/seq_bit_serializer_hold.sv - one-entry holding buffer with bypass (seq_hold_buf)
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_data/in_valid    : incoming word
//   in_ready            : buffer can accept (reset released and buffer empty)
//   take                : shifter loads a word this edge
//   out_valid/out_data  : word offered to the shifter (held word, else bypassed input)
//   hold_full           : buffer occupied
module seq_hold_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             take,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             hold_full
);
    logic [WIDTH-1:0] data_q;
    logic             full_q;
    logic             accept;

    assign in_ready  = rst_n & ~full_q;
    assign accept    = in_valid & in_ready;
    assign hold_full = full_q;

    // The held word always has priority; in_ready is low while it exists,
    // so a held word and a fresh accept never compete.
    assign out_valid = full_q | accept;
    assign out_data  = full_q ? data_q : in_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else if (full_q && take) begin
            full_q <= 1'b0;
        end else if (accept && !take) begin
            full_q <= 1'b1;
            data_q <= in_data;
        end
    end
endmodule

// File: rtl/seq_bit_serializer.sv
// rtl/seq_bit_serializer.sv - parallel-to-serial front end feeding a sequence detector
//   clk        : rising-edge clock
//   rst        : asynchronous reset, active-low
//   in_if      : word handshake (in_data, in_valid, in_ready)
//   shift_en   : 1 advances one bit this cycle, 0 holds everything
//   bit_out    : serial bit (detector x)
//   bit_valid  : bit_out carries word data
//   word_done  : last bit of a word is on bit_out and is being shifted out
//   busy       : shifter or holding buffer occupied
module seq_bit_serializer
    import seq_det_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    seq_bit_serializer_if.slave   in_if,
    input  logic                  shift_en,
    output logic                  bit_out,
    output logic                  bit_valid,
    output logic                  word_done,
    output logic                  busy
);
    localparam int           CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    ser_state_t       state_q, state_d;
    logic [WIDTH-1:0] shreg_q;
    logic [CW-1:0]    cnt_q;

    logic             src_valid;
    logic [WIDTH-1:0] src_data;
    logic             hold_full;
    logic             advance;
    logic             last_bit;
    logic             take;

    assign advance  = (state_q == ST_SHIFT) && shift_en;
    assign last_bit = (state_q == ST_SHIFT) && (cnt_q == LAST_CNT);
    // A load slot exists when idle, or on the edge that shifts out the
    // last bit; using that slot is what keeps consecutive words gap-free.
    assign take     = (state_q == ST_IDLE) || (advance && last_bit);

    seq_hold_buf #(.WIDTH(WIDTH)) u_hold (
        .clk       (clk),
        .rst_n     (rst),
        .in_data   (in_if.in_data),
        .in_valid  (in_if.in_valid),
        .in_ready  (in_if.in_ready),
        .take      (take),
        .out_valid (src_valid),
        .out_data  (src_data),
        .hold_full (hold_full)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (src_valid) begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (advance && last_bit && !src_valid) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg_q <= '0;
            cnt_q   <= '0;
        end else if (take && src_valid) begin
            shreg_q <= src_data;
            cnt_q   <= '0;
        end else if (advance && !last_bit) begin
            shreg_q <= MSB_FIRST ? {shreg_q[WIDTH-2:0], SEQ_IDLE_BIT}
                                 : {SEQ_IDLE_BIT, shreg_q[WIDTH-1:1]};
            cnt_q   <= cnt_q + CW'(1);
        end
    end

    assign bit_valid = (state_q == ST_SHIFT);
    assign bit_out   = bit_valid ? (MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0])
                                 : SEQ_IDLE_BIT;
    assign word_done = advance && last_bit;
    assign busy      = bit_valid || hold_full;
endmodule
